// File: rtl/game_flow_ctrl.sv
// Rhythm-game top-level sequencer: debounces the three panel buttons, runs the
// song-select menu, and sequences start / play / result phases for the loader and judge.
module game_flow_ctrl #(
  parameter int NUM_SONGS       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESULT_CYCLES   = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_button,
  input  logic       blue_button,
  input  logic       yellow_button,
  input  logic       finish,
  output logic [1:0] cursor,
  output logic [1:0] song_id,
  output logic       start,
  output logic       score_clr,
  output logic       playing,
  output logic       hit_red,
  output logic       hit_blue,
  output logic       abort,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RESULT_CYCLES);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RES_LAST = RW'(RESULT_CYCLES - 1);
  localparam logic [1:0]    CUR_LAST = 2'(NUM_SONGS - 1);

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_START  = 2'd1,
    S_PLAY   = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  logic [2:0] raw_btn;
  logic [2:0] press;

  assign raw_btn = {yellow_button, blue_button, red_button};

  // Per-button synchronizer + debouncer; press pulse fires on the rising edge of the debounced level.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic          db_q;
      logic          db_dly_q;
      logic          press_q;
      logic [DW-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          db_q     <= 1'b0;
          db_dly_q <= 1'b0;
          press_q  <= 1'b0;
          cnt_q    <= '0;
        end else begin
          sync1_q  <= raw_btn[gi];
          sync2_q  <= sync1_q;
          db_dly_q <= db_q;
          press_q  <= db_q & ~db_dly_q;
          if (sync2_q == db_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_LAST) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic p_red;
  logic p_blue;
  logic p_yel;

  assign p_red  = press[0];
  assign p_blue = press[1];
  assign p_yel  = press[2];

  state_e        state_q;
  logic [1:0]    cursor_q;
  logic [1:0]    song_q;
  logic          start_q;
  logic          clr_q;
  logic          playing_q;
  logic          abort_q;
  logic [RW-1:0] res_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_MENU;
      cursor_q  <= 2'd0;
      song_q    <= 2'd0;
      start_q   <= 1'b0;
      clr_q     <= 1'b0;
      playing_q <= 1'b0;
      abort_q   <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_MENU: begin
          if (p_yel) begin
            song_q  <= cursor_q;
            state_q <= S_START;
            start_q <= 1'b1;
            clr_q   <= 1'b1;
          end else if (p_red && !p_blue) begin
            cursor_q <= (cursor_q == 2'd0) ? CUR_LAST : cursor_q - 2'd1;
          end else if (p_blue && !p_red) begin
            cursor_q <= (cursor_q == CUR_LAST) ? 2'd0 : cursor_q + 2'd1;
          end
        end
        S_START: begin
          state_q   <= S_PLAY;
          playing_q <= 1'b1;
        end
        S_PLAY: begin
          // End of song wins over a simultaneous abort request.
          if (finish) begin
            state_q   <= S_RESULT;
            playing_q <= 1'b0;
            res_cnt_q <= '0;
          end else if (p_yel) begin
            state_q   <= S_MENU;
            playing_q <= 1'b0;
            abort_q   <= 1'b1;
          end
        end
        S_RESULT: begin
          if (p_yel || res_cnt_q == RES_LAST) begin
            state_q <= S_MENU;
          end else begin
            res_cnt_q <= res_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_MENU;
      endcase
    end
  end

  assign state     = state_q;
  assign cursor    = cursor_q;
  assign song_id   = song_q;
  assign start     = start_q;
  assign score_clr = clr_q;
  assign playing   = playing_q;
  assign abort     = abort_q;
  assign hit_red   = p_red & playing_q;
  assign hit_blue  = p_blue & playing_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus pushes expected output snapshots with
// their cycle; a monitor pops one whenever the DUT outputs change.
module tb_game_flow_ctrl;

  localparam int D  = 4;
  localparam int R  = 8;
  localparam int NS = 4;

  localparam logic [1:0] M_MENU   = 2'd0;
  localparam logic [1:0] M_START  = 2'd1;
  localparam logic [1:0] M_PLAY   = 2'd2;
  localparam logic [1:0] M_RESULT = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       red_b, blue_b, yel_b, fin;
  logic [1:0] dut_cursor, dut_song, dut_state;
  logic       dut_start, dut_clr, dut_playing, dut_hit_red, dut_hit_blue, dut_abort;

  game_flow_ctrl #(
    .NUM_SONGS      (NS),
    .DEBOUNCE_CYCLES(D),
    .RESULT_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red_button   (red_b),
    .blue_button  (blue_b),
    .yellow_button(yel_b),
    .finish       (fin),
    .cursor       (dut_cursor),
    .song_id      (dut_song),
    .start        (dut_start),
    .score_clr    (dut_clr),
    .playing      (dut_playing),
    .hit_red      (dut_hit_red),
    .hit_blue     (dut_hit_blue),
    .abort        (dut_abort),
    .state        (dut_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] state;
    logic [1:0] cursor;
    logic [1:0] song_id;
    logic       start;
    logic       score_clr;
    logic       playing;
    logic       hit_red;
    logic       hit_blue;
    logic       abort;
  } snap_t;

  typedef struct {
    int    at;
    snap_t s;
  } exp_t;

  exp_t  exp_q[$];
  snap_t m_snap;
  int    m_res_x;
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;

  function automatic snap_t dut_snap();
    snap_t s;
    s.state     = dut_state;
    s.cursor    = dut_cursor;
    s.song_id   = dut_song;
    s.start     = dut_start;
    s.score_clr = dut_clr;
    s.playing   = dut_playing;
    s.hit_red   = dut_hit_red;
    s.hit_blue  = dut_hit_blue;
    s.abort     = dut_abort;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("state=%0d cursor=%0d song=%0d start=%b clr=%b playing=%b hit_r=%b hit_b=%b abort=%b",
                     s.state, s.cursor, s.song_id, s.start, s.score_clr, s.playing,
                     s.hit_red, s.hit_blue, s.abort);
  endfunction

  // Monitor: every change of the observed outputs is one transaction.
  snap_t prev;
  bit    mon_started = 1'b0;
  always @(negedge clk) begin : monitor
    snap_t cur;
    exp_t  e;
    if (mon_en) begin
      cur = dut_snap();
      if (!mon_started) begin
        prev        = cur;
        mon_started = 1'b1;
      end else if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cycle %0d got %s, required no change", cyc, fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || e.s !== cur) begin
            n_fail++;
            $display("FAIL scoreboard: got cycle %0d %s, required cycle %0d %s",
                     cyc, fmt(cur), e.at, fmt(e.s));
          end else begin
            $display("ok   cycle %0d %s", cyc, fmt(cur));
          end
        end
        prev = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int at);
    exp_t e;
    e.at = at;
    e.s  = m_snap;
    exp_q.push_back(e);
  endtask

  // Game-level reference: x is the edge at which the flow reacts to the events.
  task automatic apply(input int x, input bit r, input bit b, input bit y, input bit f);
    case (m_snap.state)
      M_MENU: begin
        if (y) begin
          m_snap.state = M_START; m_snap.song_id = m_snap.cursor;
          m_snap.start = 1'b1; m_snap.score_clr = 1'b1;
          push(x);
          m_snap.state = M_PLAY; m_snap.start = 1'b0; m_snap.score_clr = 1'b0;
          m_snap.playing = 1'b1;
          push(x + 1);
        end else if (r && !b) begin
          m_snap.cursor = 2'((int'(m_snap.cursor) + NS - 1) % NS);
          push(x);
        end else if (b && !r) begin
          m_snap.cursor = 2'((int'(m_snap.cursor) + 1) % NS);
          push(x);
        end
      end
      M_PLAY: begin
        if (r || b) begin
          m_snap.hit_red = r; m_snap.hit_blue = b;
          push(x - 1);
          m_snap.hit_red = 1'b0; m_snap.hit_blue = 1'b0;
        end
        if (f) begin
          m_snap.state = M_RESULT; m_snap.playing = 1'b0; m_res_x = x;
        end else if (y) begin
          m_snap.state = M_MENU; m_snap.playing = 1'b0; m_snap.abort = 1'b1;
        end
        if (r || b || f || y) push(x);
        if (m_snap.abort) begin
          m_snap.abort = 1'b0;
          push(x + 1);
        end
      end
      M_RESULT: begin
        if (y) begin
          m_snap.state = M_MENU;
          push(x);
        end
      end
      default: ;
    endcase
  endtask

  task automatic set_btn(input bit r, input bit b, input bit y);
    red_b = r; blue_b = b; yel_b = y;
  endtask

  function automatic int rand_hold();
    return int'($urandom_range(D, D + 6));
  endfunction

  // A clean press held for `hold` cycles reacts at edge T+3+D (T = first sampling edge).
  task automatic press(input bit r, input bit b, input bit y, input int hold);
    int t;
    t = cyc + 1;
    set_btn(r, b, y);
    apply(t + 3 + D, r, b, y, 1'b0);
    tick(hold);
    set_btn(1'b0, 1'b0, 1'b0);
    tick(D + 4 + int'($urandom_range(0, 4)));
  endtask

  task automatic glitch(input bit r, input bit b, input bit y, input int len);
    set_btn(r, b, y);
    tick(len);
    set_btn(1'b0, 1'b0, 1'b0);
    tick(D + 4);
  endtask

  task automatic finish_pulse();
    fin = 1'b1;
    apply(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    fin = 1'b0;
  endtask

  task automatic result_wait();
    if (m_snap.state == M_RESULT) begin
      m_snap.state = M_MENU;
      push(m_res_x + R);
    end
    tick(m_res_x + R + 2 - cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if (m_snap !== '0) begin
      m_snap = '0;
      push(cyc + 1);
    end
    tick(1);
    rst = 1'b0;
  endtask

  task automatic goto_cursor(input logic [1:0] target);
    while (m_snap.cursor != target) press(1'b0, 1'b1, 1'b0, rand_hold());
  endtask

  task automatic rand_glitch();
    int k;
    k = int'($urandom_range(0, 2));
    glitch(k == 0, k == 1, k == 2, int'($urandom_range(1, D - 1)));
  endtask

  initial begin : stimulus
    int    t, x, e, op;
    snap_t rst_snap;
    rst_snap = '0;
    rst = 1'b1; fin = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0);
    m_snap = '0; m_res_x = 0;
    tick(3);
    rst = 1'b0;
    n_checks++;
    if (dut_snap() !== rst_snap) begin
      n_fail++;
      $display("FAIL reset_state: got %s, required %s", fmt(dut_snap()), fmt(rst_snap));
    end
    mon_en = 1'b1;
    tick(1);

    // Menu navigation and wrap-around.
    repeat (3) press(1'b0, 1'b1, 1'b0, rand_hold());
    press(1'b1, 1'b0, 1'b0, rand_hold());
    do_reset();
    tick(2);
    press(1'b1, 1'b0, 1'b0, rand_hold());

    // Glitches are filtered; a 10-cycle press gives one step; red+blue together is a no-op.
    glitch(1'b1, 1'b0, 1'b0, 3);
    rand_glitch();
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b1, 1'b1, 1'b0, rand_hold());
    repeat (8) begin
      op = int'($urandom_range(0, 2));
      if (op == 2) rand_glitch();
      else press(op == 0, op == 1, 1'b0, rand_hold());
    end

    // Confirm song 2, play with hits, finish, red press inside RESULT.
    goto_cursor(2'd2);
    press(1'b0, 1'b0, 1'b1, rand_hold());
    press(1'b1, 1'b0, 1'b0, rand_hold());
    press(1'b0, 1'b1, 1'b0, rand_hold());
    press(1'b1, 1'b1, 1'b0, rand_hold());
    finish_pulse();
    t = cyc + 1;
    set_btn(1'b1, 1'b0, 1'b0);
    apply(t + 3 + D, 1'b1, 1'b0, 1'b0, 1'b0);
    result_wait();
    set_btn(1'b0, 1'b0, 1'b0);
    tick(D + 6);

    // finish coincident with p_yel in PLAY: RESULT, no abort.
    press(1'b0, 1'b0, 1'b1, rand_hold());
    set_btn(1'b0, 1'b0, 1'b1);
    t = cyc + 1;
    x = t + 3 + D;
    tick(x - 1 - cyc);
    fin = 1'b1;
    apply(x, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    fin = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0);
    result_wait();
    tick(D + 4);

    // Yellow skips RESULT early.
    press(1'b0, 1'b0, 1'b1, rand_hold());
    set_btn(1'b0, 1'b0, 1'b1);
    t = cyc + 1;
    x = t + 3 + D;
    e = x - 3;
    tick(e - 1 - cyc);
    finish_pulse();
    apply(x, 1'b0, 1'b0, 1'b1, 1'b0);
    set_btn(1'b0, 1'b0, 1'b0);
    tick(x + D + 6 - cyc);

    // Abort from PLAY, then finish held as a level in MENU is ignored.
    press(1'b0, 1'b0, 1'b1, rand_hold());
    press(1'b0, 1'b0, 1'b1, rand_hold());
    fin = 1'b1;
    tick(5);
    fin = 1'b0;
    tick(2);

    // Yellow beats red in MENU; then reset mid-PLAY with blue mid-debounce.
    press(1'b1, 1'b0, 1'b1, rand_hold());
    set_btn(1'b0, 1'b1, 1'b0);
    tick(3);
    do_reset();
    tick(1);
    set_btn(1'b0, 1'b0, 1'b0);
    tick(D + 8);
    press(1'b0, 1'b1, 1'b0, rand_hold());

    // Randomized mixed traffic.
    repeat (30) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: press(1'b1, 1'b0, 1'b0, rand_hold());
        1: press(1'b0, 1'b1, 1'b0, rand_hold());
        2: press(1'b1, 1'b1, 1'b0, rand_hold());
        3: press(1'b0, 1'b0, 1'b1, rand_hold());
        4: rand_glitch();
        default: begin
          if (m_snap.state == M_PLAY) begin
            finish_pulse();
            result_wait();
          end else begin
            fin = 1'b1;
            tick(int'($urandom_range(1, 4)));
            fin = 1'b0;
            tick(2);
          end
        end
      endcase
    end

    tick(D + 6);
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d expected transactions never seen, required 0 (first at cycle %0d)",
               exp_q.size(), exp_q[0].at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test by time limit, required completion");
    $fatal(1);
  end

endmodule
